// File: rtl/bus_pkg.sv
// Shared definitions for the shared-bus generator: ID width, per-bus FSM states
// and a helper that pulls the destination ID out of a packet of any width.
package bus_pkg;

    localparam int ID_W      = 8;
    localparam int MAX_PKT_W = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } bus_state_t;

    // Callers zero-extend their packet to MAX_PKT_W and pass its real width.
    function automatic logic [ID_W-1:0] pkt_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int pkt_w);
        logic [MAX_PKT_W-1:0] shifted_v;
        shifted_v = pkt >> (pkt_w - ID_W);
        return shifted_v[ID_W-1:0];
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// One shared bus: round-robin pop from a pending device, then push the packet to
// its destination, to every other device on broadcast, or drop it if the ID is unknown.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [drvrs-1:0]               pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [drvrs-1:0]               pop,
    output logic [drvrs-1:0]               push,
    output logic [drvrs-1:0][pckg_sz-1:0]  D_push
);

    localparam int SRC_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    bus_state_t          state_r, state_s;
    logic [SRC_W-1:0]    src_r, src_s;
    logic [SRC_W-1:0]    ptr_r, ptr_s;
    logic [drvrs-1:0]    pop_r, pop_s;
    logic [drvrs-1:0]    push_r, push_s;
    logic [pckg_sz-1:0]  pkt_r, pkt_s;

    logic                found_s;
    logic [SRC_W-1:0]    grant_s;
    logic [pckg_sz-1:0]  head_s;
    logic [ID_W-1:0]     dest_s;

    // Round-robin search of pndng starting at the pointer, wrapping modulo drvrs
    always_comb begin
        logic [SRC_W:0] idx_v;
        logic           hit_v;
        found_s = 1'b0;
        grant_s = '0;
        idx_v   = '0;
        hit_v   = 1'b0;
        for (int off = 0; off < drvrs; off++) begin
            idx_v   = {1'b0, ptr_r} + (SRC_W+1)'(off);
            idx_v   = (idx_v >= (SRC_W+1)'(drvrs)) ? (idx_v - (SRC_W+1)'(drvrs)) : idx_v;
            hit_v   = pndng[idx_v[SRC_W-1:0]] & ~found_s;
            grant_s = hit_v ? idx_v[SRC_W-1:0] : grant_s;
            found_s = found_s | hit_v;
        end
    end

    // Head of the granted device's FIFO and its destination ID
    always_comb begin
        head_s = D_pop[src_r];
        dest_s = pkt_dest(MAX_PKT_W'(head_s), pckg_sz);
    end

    // Next-state and next-output logic; outputs are registered one step ahead
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        ptr_s   = ptr_r;
        pop_s   = '0;
        push_s  = '0;
        pkt_s   = pkt_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s        = POP;
                    src_s          = grant_s;
                    pop_s[grant_s] = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            POP: begin
                // pop is high this cycle, so head_s is the packet being removed
                pkt_s   = head_s;
                state_s = PUSH;
                if (dest_s == broadcast) begin
                    push_s        = '1;
                    push_s[src_r] = 1'b0;
                end else if (int'(dest_s) < drvrs) begin
                    push_s[dest_s[SRC_W-1:0]] = 1'b1;
                end else begin
                    push_s = '0;
                end
            end
            PUSH: begin
                state_s = IDLE;
                ptr_s   = (src_r == SRC_W'(drvrs - 1)) ? '0 : (src_r + 1'b1);
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, pointer, packet and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            src_r   <= '0;
            ptr_r   <= '0;
            pop_r   <= '0;
            push_r  <= '0;
            pkt_r   <= '0;
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            ptr_r   <= ptr_s;
            pop_r   <= pop_s;
            push_r  <= push_s;
            pkt_r   <= pkt_s;
        end
    end

    assign pop    = pop_r;
    assign push   = push_r;
    assign D_push = {drvrs{pkt_r}};

endmodule

// File: rtl/bs_gnrt.sv
// Shared-bus generator: `bits` independent buses, each serving `drvrs` devices
// through its own round-robin bus_arbiter.
module bs_gnrt
    import bus_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [bits-1:0][drvrs-1:0]                pndng,
    output logic [bits-1:0][drvrs-1:0]                push,
    output logic [bits-1:0][drvrs-1:0]                pop,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push
);

    for (genvar b = 0; b < bits; b++) begin : g_bus
        bus_arbiter #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_arb (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[b]),
            .D_pop  (D_pop[b]),
            .pop    (pop[b]),
            .push   (push[b]),
            .D_push (D_push[b])
        );
    end

endmodule

// File: tb/tb_bs_gnrt.sv
// Self-checking bench for bs_gnrt: device transmit FIFOs are queues, and a
// transaction-level model predicts every pop/push cycle and the delivered data.
module tb_bs_gnrt;

    localparam int BITS  = 1;
    localparam int DRVRS = 4;
    localparam int PSZ   = 16;

    logic                                   clk = 1'b0;
    logic                                   reset;
    logic [BITS-1:0][DRVRS-1:0]             pndng;
    logic [BITS-1:0][DRVRS-1:0]             push;
    logic [BITS-1:0][DRVRS-1:0]             pop;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]    D_pop;
    logic [BITS-1:0][DRVRS-1:0][PSZ-1:0]    D_push;

    bs_gnrt #(
        .bits      (BITS),
        .drvrs     (DRVRS),
        .pckg_sz   (PSZ),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .push   (push),
        .pop    (pop),
        .D_pop  (D_pop),
        .D_push (D_push)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // device transmit FIFOs
    logic [PSZ-1:0] q [DRVRS][$];
    int             pop_log[$];

    // transaction model state
    int             edge_n;
    int             arb_e;
    int             cur_src;
    int             ptr;
    logic [PSZ-1:0] cur_pkt;
    bit             rnd_on;
    logic [DRVRS-1:0] last_push;
    logic [PSZ-1:0]   last_dpush;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receivers a packet from src must reach, derived from its destination ID
    function automatic logic [DRVRS-1:0] exp_mask(input logic [PSZ-1:0] p, input int src);
        logic [DRVRS-1:0] m;
        logic [PSZ-1:0]   pk;
        int               d;
        pk = p;
        d  = int'(pk[PSZ-1:PSZ-8]);
        for (int k = 0; k < DRVRS; k++)
            m[k] = (d == 255) ? (k != src) : (k == d);
        return m;
    endfunction

    function automatic bit any_pending();
        bit a;
        a = 1'b0;
        for (int i = 0; i < DRVRS; i++)
            if (q[i].size() != 0) a = 1'b1;
        return a;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < DRVRS; i++) begin
            pndng[0][i] = (q[i].size() != 0);
            D_pop[0][i] = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        edge_n  = 0;
        arb_e   = -10;
        cur_src = -1;
        ptr     = 0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < DRVRS; i++) q[i].delete();
        drive_inputs();
    endtask

    function automatic logic [PSZ-1:0] rand_pkt();
        int r;
        logic [7:0] d;
        r = int'($urandom_range(0, 9));
        if (r < 6)      d = 8'(r % DRVRS);
        else if (r < 8) d = 8'hFF;
        else            d = 8'($urandom_range(DRVRS, 254));
        return {d, 8'($urandom)};
    endfunction

    // One clock: predict the edge, let it happen, compare, then act as the FIFOs
    task automatic step();
        logic [DRVRS-1:0] e_pop, e_push;
        logic [PSZ-1:0]   e_pkt;
        int               consume_dev;
        e_pop       = '0;
        e_push      = '0;
        consume_dev = -1;
        edge_n++;
        if (cur_src >= 0 && edge_n == arb_e + 1) begin
            e_push      = exp_mask(cur_pkt, cur_src);
            consume_dev = cur_src;
        end else if (cur_src >= 0 && edge_n == arb_e + 2) begin
            ptr     = (cur_src + 1) % DRVRS;
            cur_src = -1;
        end
        if (cur_src < 0 && edge_n >= arb_e + 3) begin
            for (int off = 0; off < DRVRS; off++) begin
                int i;
                i = (ptr + off) % DRVRS;
                if (cur_src < 0 && q[i].size() != 0) begin
                    cur_src = i;
                    arb_e   = edge_n;
                    cur_pkt = q[i][0];
                    e_pop   = DRVRS'(1) << i;
                    pop_log.push_back(i);
                end
            end
        end
        e_pkt = cur_pkt;
        @(posedge clk);
        #1;
        check("pop", 64'(pop[0]), 64'(e_pop));
        check("push", 64'(push[0]), 64'(e_push));
        if (e_push != '0) begin
            for (int k = 0; k < DRVRS; k++)
                check("d_push", 64'(D_push[0][k]), 64'(e_pkt));
            last_push  = push[0];
            last_dpush = D_push[0][0];
        end
        if (consume_dev >= 0) void'(q[consume_dev].pop_front());
        if (rnd_on) begin
            for (int i = 0; i < DRVRS; i++)
                if ($urandom_range(0, 99) < 6) q[i].push_back(rand_pkt());
        end
        drive_inputs();
    endtask

    task automatic drain(input int limit);
        int guard;
        guard = 0;
        while ((any_pending() || cur_src >= 0) && guard < limit) begin
            step();
            guard++;
        end
        n_cmp++;
        assert (guard < limit) else begin
            n_err++;
            $error("FAIL drain_timeout observed=%0d expected_below=%0d", guard, limit);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rr_exp[4];
        int iv_exp[2];
        rr_exp = '{0, 3, 0, 3};
        iv_exp = '{2, 3};
        reset  = 1'b1;
        rnd_on = 1'b0;
        last_push  = '0;
        last_dpush = '0;
        model_reset();
        clear_queues();

        // Reset holds everything quiet even with all devices pending
        for (int i = 0; i < DRVRS; i++) q[i].push_back({8'((i + 1) % DRVRS), 8'(8'h30 + i)});
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("rst_pop", 64'(pop[0]), 64'd0);
            check("rst_push", 64'(push[0]), 64'd0);
            check("rst_dpush", 64'(D_push[0]), 64'd0);
        end
        reset = 1'b0;
        model_reset();
        pop_log.delete();
        drain(100);
        check("rst_release_order_n", 64'(pop_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("rst_release_order", 64'(pop_log[i]), 64'(i));

        // Unicast from device 0 to device 2
        last_push = '0;
        q[0].push_back(16'h02AB);
        drive_inputs();
        drain(100);
        check("unicast_push", 64'(last_push), 64'h4);
        check("unicast_data", 64'(last_dpush), 64'h02AB);

        // Broadcast from device 1
        last_push = '0;
        q[1].push_back(16'hFF55);
        drive_inputs();
        drain(100);
        check("bcast_push", 64'(last_push), 64'hD);
        check("bcast_data", 64'(last_dpush), 64'hFF55);

        // Round robin between devices 0 and 3
        pulse_reset();
        q[0].push_back(16'h0101);
        q[0].push_back(16'h0102);
        q[3].push_back(16'h0203);
        q[3].push_back(16'h0204);
        drive_inputs();
        pop_log.delete();
        drain(100);
        check("rr_count", 64'(pop_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("rr_order", 64'(pop_log[i]), 64'(rr_exp[i]));

        // Invalid destination is popped and dropped, then the next device is served
        q[2].push_back(16'h0711);
        q[3].push_back(16'h0312);
        drive_inputs();
        pop_log.delete();
        drain(100);
        check("inv_count", 64'(pop_log.size()), 64'd2);
        for (int i = 0; i < 2 && i < pop_log.size(); i++)
            check("inv_order", 64'(pop_log[i]), 64'(iv_exp[i]));

        // Asynchronous reset during the pop cycle aborts the transfer
        pulse_reset();
        q[1].push_back(16'h0322);
        drive_inputs();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_pop", 64'(pop[0]), 64'd0);
        check("arst_push", 64'(push[0]), 64'd0);
        clear_queues();
        @(posedge clk);
        #1;
        check("arst_hold_push", 64'(push[0]), 64'd0);
        #2;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) step();

        // Randomised traffic against the model
        rnd_on = 1'b1;
        for (int c = 0; c < 600; c++) step();
        rnd_on = 1'b0;
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
